// File: rtl/demux_stream_1ton_if.sv
// Stream bundle between one producer and the N-lane demux.
// Handshake: a word moves on a lane when valid and ready are both 1 at the rising
// edge; valid never waits on ready, and a stalled sender holds data/sel/bcast stable.
interface demux_stream_1ton_if #(
  parameter int DW   = 8,
  parameter int N    = 8,
  parameter int SELW = 3
);
  logic                in_valid;
  logic                in_ready;
  logic [DW-1:0]       in_data;
  logic [SELW-1:0]     in_sel;
  logic                in_bcast;
  logic [N-1:0]        out_valid;
  logic [N-1:0]        out_ready;
  logic [N*DW-1:0]     out_data;

  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/demux_stream_1ton.sv
// Registered 1-to-N stream demux: one holding register per lane, broadcast mode,
// and out-of-range selects dropped with a pulse and a saturating counter.
module demux_stream_1ton #(
  parameter int DW   = 8,
  parameter int N    = 8,
  parameter int SELW = 3,
  parameter int CNTW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  demux_stream_1ton_if.slave  bus,
  output logic                drop_err,
  output logic [CNTW-1:0]     drop_cnt
);
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [N-1:0]          valid_q;
  logic [N-1:0][DW-1:0]  data_q;
  logic [N-1:0]          free;
  logic [N-1:0]          sel_hot;
  logic [N-1:0]          load;
  logic                  in_range;
  logic                  accept;
  logic                  drop;

  // A lane is free when empty or when its held word leaves this same edge.
  assign free     = ~valid_q | bus.out_ready;
  assign in_range = (int'(bus.in_sel) < N);

  for (genvar i = 0; i < N; i++) begin : g_sel
    assign sel_hot[i] = (int'(bus.in_sel) == i);
  end

  // Out-of-range words are always swallowed so the producer never stalls on them.
  assign bus.in_ready = bus.in_bcast ? (&free)
                      : in_range     ? (|(sel_hot & free))
                      :                1'b1;

  assign accept = bus.in_valid & bus.in_ready;
  assign load   = ({N{accept &  bus.in_bcast}})
                | ({N{accept & ~bus.in_bcast}} & sel_hot);
  assign drop   = accept & ~bus.in_bcast & ~in_range;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= '0;
      data_q   <= '0;
      drop_err <= 1'b0;
      drop_cnt <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (load[i]) begin
          valid_q[i] <= 1'b1;
          data_q[i]  <= bus.in_data;
        end else if (bus.out_ready[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
      drop_err <= drop;
      if (drop && (drop_cnt != CNT_MAX)) begin
        drop_cnt <= drop_cnt + CNTW'(1);
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
endmodule

// File: tb/tb_demux_stream_1ton.sv
// Bench for demux_stream_1ton: an 8-lane instance driven from a vector table and a
// 5-lane instance with a 2-bit drop counter for out-of-range and saturation cases.
module tb_demux_stream_1ton;
  logic clk;
  logic rst_n;

  demux_stream_1ton_if #(.DW(8), .N(8), .SELW(3)) if8 ();
  demux_stream_1ton_if #(.DW(8), .N(5), .SELW(3)) if5 ();

  logic       derr8;
  logic [7:0] dcnt8;
  logic       derr5;
  logic [1:0] dcnt5;

  demux_stream_1ton #(.DW(8), .N(8), .SELW(3), .CNTW(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(if8), .drop_err(derr8), .drop_cnt(dcnt8)
  );

  demux_stream_1ton #(.DW(8), .N(5), .SELW(3), .CNTW(2)) dut5 (
    .clk(clk), .rst_n(rst_n), .bus(if5), .drop_err(derr5), .drop_cnt(dcnt5)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[2][16][$];
  int         mdl_cnt[2];
  logic       mdl_err[2];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Called on every falling edge: inputs are stable and describe the coming edge.
  task automatic mon(input int id, input int n, input int cmax,
                     input logic iv, input logic ir, input logic [2:0] isel,
                     input logic ib, input logic [7:0] idat,
                     input logic [15:0] ov, input logic [15:0] orr,
                     input logic [127:0] od, input logic derr, input logic [7:0] dcnt);
    if (!rst_n) begin
      for (int ch = 0; ch < 16; ch++) exp_q[id][ch].delete();
      mdl_cnt[id] = 0;
      mdl_err[id] = 1'b0;
      return;
    end
    chk($sformatf("dut%0d drop_err", id), 32'(derr), 32'(mdl_err[id]));
    chk($sformatf("dut%0d drop_cnt", id), 32'(dcnt), 32'(mdl_cnt[id]));
    mdl_err[id] = 1'b0;
    for (int ch = 0; ch < n; ch++) begin
      chk($sformatf("dut%0d ch%0d valid", id, ch), 32'(ov[ch]),
          32'(exp_q[id][ch].size() != 0));
      if (ov[ch] && exp_q[id][ch].size() != 0) begin
        chk($sformatf("dut%0d ch%0d data", id, ch), 32'(od[ch*8 +: 8]),
            32'(exp_q[id][ch][0]));
        if (orr[ch]) void'(exp_q[id][ch].pop_front());
      end
    end
    if (iv && ir) begin
      if (ib) begin
        for (int ch = 0; ch < n; ch++) exp_q[id][ch].push_back(idat);
      end else if (int'(isel) < n) begin
        exp_q[id][isel].push_back(idat);
      end else begin
        mdl_err[id] = 1'b1;
        if (mdl_cnt[id] < cmax) mdl_cnt[id]++;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, 8, 255, if8.in_valid, if8.in_ready, if8.in_sel, if8.in_bcast, if8.in_data,
        16'(if8.out_valid), 16'(if8.out_ready), 128'(if8.out_data), derr8, dcnt8);
    mon(1, 5, 3, if5.in_valid, if5.in_ready, if5.in_sel, if5.in_bcast, if5.in_data,
        16'(if5.out_valid), 16'(if5.out_ready), 128'(if5.out_data), derr5, 8'(dcnt5));
  end

  // ---------------- driver ----------------
  typedef struct packed {
    logic       v;
    logic [2:0] sel;
    logic       b;
    logic [7:0] d;
    logic [7:0] ordy;
    logic       exp_rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic [2:0] s, input logic b,
                              input logic [7:0] d, input logic [7:0] r, input logic e);
    vec_t t;
    t.v = v; t.sel = s; t.b = b; t.d = d; t.ordy = r; t.exp_rdy = e;
    return t;
  endfunction

  task automatic cyc(input logic v8, input logic [2:0] s8, input logic b8,
                     input logic [7:0] d8, input logic [7:0] r8,
                     input logic v5, input logic [2:0] s5, input logic [7:0] d5,
                     input logic [4:0] r5);
    @(posedge clk);
    #1;
    if8.in_valid = v8; if8.in_sel = s8; if8.in_bcast = b8; if8.in_data = d8; if8.out_ready = r8;
    if5.in_valid = v5; if5.in_sel = s5; if5.in_bcast = 1'b0; if5.in_data = d5; if5.out_ready = r5;
    @(negedge clk);
  endtask

  // ---------------- test ----------------
  initial begin
    rst_n = 1'b0;
    if8.in_valid = 1'b0; if8.in_sel = 3'd0; if8.in_bcast = 1'b0; if8.in_data = 8'h00;
    if8.out_ready = 8'hFF;
    if5.in_valid = 1'b0; if5.in_sel = 3'd0; if5.in_bcast = 1'b0; if5.in_data = 8'h00;
    if5.out_ready = 5'h1F;

    // sweep, backpressure, broadcast, independence
    for (int i = 0; i < 8; i++) vecs.push_back(mk(1'b1, 3'(i), 1'b0, 8'hA5, 8'hFF, 1'b1));
    vecs.push_back(mk(1'b0, 3'd0, 1'b0, 8'h00, 8'hFF, 1'b1));
    vecs.push_back(mk(1'b1, 3'd3, 1'b0, 8'h11, 8'hF7, 1'b1));
    vecs.push_back(mk(1'b1, 3'd3, 1'b0, 8'h22, 8'hF7, 1'b0));
    vecs.push_back(mk(1'b1, 3'd3, 1'b0, 8'h22, 8'hF7, 1'b0));
    vecs.push_back(mk(1'b1, 3'd3, 1'b0, 8'h22, 8'hFF, 1'b1));
    vecs.push_back(mk(1'b0, 3'd3, 1'b0, 8'h00, 8'hFF, 1'b1));
    vecs.push_back(mk(1'b1, 3'd0, 1'b1, 8'h5C, 8'hFF, 1'b1));
    vecs.push_back(mk(1'b0, 3'd0, 1'b0, 8'h00, 8'hBF, 1'b1));
    vecs.push_back(mk(1'b1, 3'd0, 1'b1, 8'hC3, 8'hBF, 1'b0));
    vecs.push_back(mk(1'b1, 3'd0, 1'b1, 8'hC3, 8'hBF, 1'b0));
    vecs.push_back(mk(1'b1, 3'd0, 1'b1, 8'hC3, 8'hFF, 1'b1));
    vecs.push_back(mk(1'b0, 3'd0, 1'b0, 8'h00, 8'hFF, 1'b1));
    vecs.push_back(mk(1'b1, 3'd1, 1'b0, 8'h77, 8'hFD, 1'b1));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1'b1, 3'd2, 1'b0, 8'(8'h80 + i), 8'hFD, 1'b1));
    vecs.push_back(mk(1'b1, 3'd1, 1'b0, 8'h78, 8'hFD, 1'b0));
    vecs.push_back(mk(1'b1, 3'd1, 1'b0, 8'h78, 8'hFF, 1'b1));
    vecs.push_back(mk(1'b0, 3'd0, 1'b0, 8'h00, 8'hFF, 1'b1));

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid8", 32'(if8.out_valid), 32'h0);
    chk("reset out_valid5", 32'(if5.out_valid), 32'h0);
    chk("reset drop_err8", 32'(derr8), 32'h0);
    chk("reset drop_cnt8", 32'(dcnt8), 32'h0);
    chk("reset drop_err5", 32'(derr5), 32'h0);
    chk("reset drop_cnt5", 32'(dcnt5), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      cyc(vecs[i].v, vecs[i].sel, vecs[i].b, vecs[i].d, vecs[i].ordy,
          1'b0, 3'd0, 8'h00, 5'h1F);
      chk($sformatf("vec%0d in_ready", i), 32'(if8.in_ready), 32'(vecs[i].exp_rdy));
    end

    // out-of-range drops on the 5-lane instance, ch4 stalled
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 3'd0, 1'b0, 8'h00, 8'hFF, 1'b1, 3'd6, 8'(8'hD1 + i), 5'h0F);
      chk("oor in_ready", 32'(if5.in_ready), 32'h1);
    end
    cyc(1'b0, 3'd0, 1'b0, 8'h00, 8'hFF, 1'b0, 3'd4, 8'h00, 5'h0F);
    chk("drop_cnt after 3", 32'(dcnt5), 32'd3);
    chk("drop_err third pulse", 32'(derr5), 32'h1);
    chk("ch4 empty in_ready", 32'(if5.in_ready), 32'h1);
    cyc(1'b0, 3'd0, 1'b0, 8'h00, 8'hFF, 1'b1, 3'd4, 8'h44, 5'h0F);
    chk("last lane in_ready", 32'(if5.in_ready), 32'h1);
    cyc(1'b0, 3'd0, 1'b0, 8'h00, 8'hFF, 1'b1, 3'd5, 8'hE5, 5'h0F);
    chk("sel5 in_ready", 32'(if5.in_ready), 32'h1);
    cyc(1'b0, 3'd0, 1'b0, 8'h00, 8'hFF, 1'b1, 3'd7, 8'hE7, 5'h0F);
    chk("sel7 in_ready", 32'(if5.in_ready), 32'h1);
    cyc(1'b0, 3'd0, 1'b0, 8'h00, 8'hFF, 1'b0, 3'd4, 8'h00, 5'h0F);
    chk("ch4 full in_ready", 32'(if5.in_ready), 32'h0);
    chk("drop_cnt saturated", 32'(dcnt5), 32'd3);
    chk("drop_err fifth pulse", 32'(derr5), 32'h1);
    cyc(1'b0, 3'd0, 1'b0, 8'h00, 8'hFF, 1'b0, 3'd4, 8'h00, 5'h0F);
    chk("drop_err cleared", 32'(derr5), 32'h0);

    // reset mid-stream: ch0/ch4 full, a word to ch0 pending
    cyc(1'b1, 3'd0, 1'b0, 8'h0A, 8'hEE, 1'b0, 3'd4, 8'h00, 5'h0F);
    chk("rst fill ch0", 32'(if8.in_ready), 32'h1);
    cyc(1'b1, 3'd4, 1'b0, 8'h4B, 8'hEE, 1'b0, 3'd4, 8'h00, 5'h0F);
    chk("rst fill ch4", 32'(if8.in_ready), 32'h1);
    cyc(1'b1, 3'd0, 1'b0, 8'hF0, 8'hEE, 1'b0, 3'd4, 8'h00, 5'h0F);
    chk("rst pending stalled", 32'(if8.in_ready), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    if8.in_valid = 1'b0;
    @(negedge clk);
    chk("post-rst in_ready8", 32'(if8.in_ready), 32'h1);
    chk("post-rst out_valid8", 32'(if8.out_valid), 32'h0);
    chk("post-rst out_valid5", 32'(if5.out_valid), 32'h0);
    chk("post-rst drop_cnt5", 32'(dcnt5), 32'h0);

    repeat (3) cyc(1'b0, 3'd0, 1'b0, 8'h00, 8'hFF, 1'b0, 3'd0, 8'h00, 5'h1F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/demux_stream_1ton.md
Name: demux_stream_1ton

Overview:
- Registered 1-to-N stream demultiplexer with valid/ready handshake on the input and on every output channel.
- Parametrised successor of the fixed 1-to-8 combinational demux: width and channel count are generic, and each output has its own holding register so channels drain independently.
- Adds a broadcast mode and out-of-range select detection with a saturating drop counter.
- Sits between a single producer and N consumer lanes.

Parameters:
- DW, 8, data width in bits.
- N, 8, number of output channels (2..16).
- SELW, 3, select width; must satisfy 2**SELW >= N.
- CNTW, 8, width of the drop counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the input word this cycle.
- in_data  input  DW  input word.
- in_sel  input  SELW  destination channel index.
- in_bcast  input  1  1 = deliver the word to all N channels; in_sel is ignored.
- out_valid  output  N  bit i = channel i holds a word.
- out_ready  input  N  bit i = consumer i takes the word.
- out_data  output  N*DW  channel i word at bits [i*DW +: DW].
- drop_err  output  1  one-cycle pulse when an out-of-range word is dropped.
- drop_cnt  output  CNTW  saturating count of dropped words.

Behaviour:
- One clock, one synchronous active-low reset. Reset is sampled on the rising clk edge while rst_n=0.
- Reset values: out_valid=0, out_data=0, drop_err=0, drop_cnt=0. Reset overrides any transfer in the same cycle and discards held words.
- Channel i is "free" in a cycle when out_valid[i]=0 or out_ready[i]=1. A word held and taken in the same cycle allows a same-cycle refill.
- in_ready is combinational from registered state and out_ready; it never depends on in_valid.
  - Unicast (in_bcast=0, in_sel<N): in_ready = free[in_sel].
  - Broadcast (in_bcast=1): in_ready = AND of free over all N channels. Broadcast is all-or-nothing; there are no partial broadcasts.
  - Out-of-range (in_bcast=0, in_sel>=N): in_ready=1 and the word is always consumed.
- Input transfer occurs when in_valid and in_ready are both 1 at the clock edge.
  - Unicast: out_data[in_sel] <= in_data and out_valid[in_sel] <= 1 on the next edge. Latency is 1 cycle, input edge to out_valid visible.
  - Broadcast: every channel loads in_data and sets out_valid.
  - Out-of-range: no channel changes. drop_err=1 for exactly the next cycle. drop_cnt increments and saturates at 2**CNTW-1 (no wrap).
- Output transfer occurs on channel i when out_valid[i] and out_ready[i] are both 1. out_valid[i] clears unless the same edge refills channel i.
- out_data[i] is stable while out_valid[i]=1 and out_ready[i]=0. The held word is never overwritten.
- Channels are independent. A stalled channel blocks only unicasts to itself and broadcasts. Throughput is 1 word/cycle when targets are free.
- out_data[i] retains its last value after draining; a bench must not check it while out_valid[i]=0.
- Input holding: while in_valid=1 and in_ready=0, the producer must hold in_data, in_sel and in_bcast stable; the block need not tolerate changes.
- Reset mid-operation: held words are lost, drop_cnt clears, and in_ready reflects the cleared state from the first cycle after reset.
- Simultaneous events: an output drain and a refill of the same channel in one cycle yields out_valid[i]=1 with the new word.

Test Plan:
- Sweep, N=8, DW=8, all out_ready=1: in_data=0xA5, in_sel=0..7, one word per cycle -> out_valid is one-hot at index sel one cycle later, out_data[sel]=0xA5, in_ready stays 1, zero bubbles.
- Backpressure: out_ready[3]=0, send 0x11 to ch3, then 0x22 to ch3 -> in_ready=0 while 0x22 is presented. Raise out_ready[3] -> 0x11 is consumed and 0x22 loads the same edge. out_data[3] never shows 0x22 before 0x11 is taken.
- Broadcast: in_bcast=1, in_data=0x5C, all outputs ready -> all 8 out_valid=1 next cycle with 0x5C. Repeat with out_ready[6]=0 and ch6 full -> in_ready=0 and no channel loads until ch6 drains.
- Out-of-range: N=5, SELW=3, in_sel=6, 3 words -> in_ready=1, no out_valid, three drop_err pulses, drop_cnt=3. With CNTW=2, 5 drops -> drop_cnt saturates at 3.
- Independence: ch1 stalled and full, unicast stream to ch2 -> ch2 continues at full rate, ch1 word unchanged.
- Reset mid-stream: rst_n=0 for one edge while ch0, ch4 full and a transfer is pending -> all out_valid=0, drop_cnt=0, the pending word is not stored, and in_ready=1 on the first cycle after reset.
